// File: rtl/target_pkg.sv
// Shared definitions for the target-practice game: LED bus width, default
// target position and the judge FSM state type.
package target_pkg;

    localparam int LED_W          = 6;
    localparam int TARGET_IDX_DEF = 3;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        JUDGE    = 2'd1,
        LOCKOUT  = 2'd2,
        WAIT_REL = 2'd3
    } judge_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debouncer for the active-low player button.
// press_evt pulses for one cycle when the debounced level falls to 0.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic stable,
    output logic press_evt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
                press_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable    = stable_q;
    assign press_evt = press_q;

endmodule

// File: rtl/hit_judge.sv
// Judge stage: scores each debounced press against the lit LED and freezes
// the sweeper for the judgement cycle plus the lockout period.
module hit_judge
    import target_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LOCKOUT_CYCLES  = 13500000,
    parameter int TARGET_IDX      = TARGET_IDX_DEF,
    parameter int SCORE_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LED_W-1:0]   led_index,
    input  logic               btn_n,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         streak,
    output logic               freeze
);

    localparam int                 LOCK_W      = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LED_W-1:0]   TARGET_MASK = LED_W'(1) << TARGET_IDX;

    logic               stable, press_evt;
    judge_state_t       state_q, state_d;
    logic [LOCK_W-1:0]  lock_q, lock_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         streak_q, streak_d;
    logic               hit_q, hit_d, miss_q, miss_d, freeze_q, freeze_d;
    logic               sample_is_hit;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_n    (btn_n),
        .stable   (stable),
        .press_evt(press_evt)
    );

    // The sample is the LED pattern present in the press_evt cycle; the verdict
    // is registered on entry to JUDGE so hit/miss and score land in that cycle.
    assign sample_is_hit = (led_index == TARGET_MASK);

    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        score_d  = score_q;
        streak_d = streak_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        case (state_q)
            ARMED: begin
                if (press_evt) begin
                    state_d = JUDGE;
                    if (sample_is_hit) begin
                        hit_d = 1'b1;
                        if (score_q != '1)     score_d  = score_q + 1'b1;
                        if (streak_q != 4'hF)  streak_d = streak_q + 1'b1;
                    end else begin
                        miss_d   = 1'b1;
                        streak_d = '0;
                        if (score_q != '0)     score_d  = score_q - 1'b1;
                    end
                end
            end
            JUDGE: begin
                state_d = LOCKOUT;
                lock_d  = LOCK_W'(LOCKOUT_CYCLES - 1);
            end
            LOCKOUT: begin
                if (lock_q == '0) state_d = WAIT_REL;
                else              lock_d  = lock_q - 1'b1;
            end
            WAIT_REL: begin
                if (stable) state_d = ARMED;
            end
            default: state_d = ARMED;
        endcase
        freeze_d = (state_d == JUDGE) || (state_d == LOCKOUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARMED;
            lock_q   <= '0;
            score_q  <= '0;
            streak_q <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            freeze_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            score_q  <= score_d;
            streak_q <= streak_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            freeze_q <= freeze_d;
        end
    end

    assign hit    = hit_q;
    assign miss   = miss_q;
    assign score  = score_q;
    assign streak = streak_q;
    assign freeze = freeze_q;

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: directed test-plan scenarios plus randomized presses,
// checked every cycle against a behavioural game model.
module tb_hit_judge;

    localparam int DEB  = 4;
    localparam int LOCK = 8;
    localparam int TGT  = 3;
    localparam logic [5:0] TMASK = 6'b1 << TGT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] led_index = 6'b0;
    logic       btn_n = 1'b1;
    logic       hit, miss, freeze;
    logic [7:0] score;
    logic [3:0] streak;

    int n_checks = 0;
    int n_fail   = 0;

    hit_judge #(
        .DEBOUNCE_CYCLES(DEB),
        .LOCKOUT_CYCLES (LOCK),
        .TARGET_IDX     (TGT),
        .SCORE_W        (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .led_index(led_index),
        .btn_n    (btn_n),
        .hit      (hit),
        .miss     (miss),
        .score    (score),
        .streak   (streak),
        .freeze   (freeze)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural game model: button history window, judgement on the
    // debounced press, freeze timer, and a wait-for-release phase.
    int m_s1 = 1, m_s2 = 1, m_stable = 1, m_press = 0;
    int mode = 0;          // 0 armed, 1 frozen, 2 waiting for release
    int freeze_left = 0;
    int m_score = 0, m_streak = 0, m_hit = 0, m_miss = 0;
    int hist[$];

    task automatic model_reset();
        m_s1 = 1; m_s2 = 1; m_stable = 1; m_press = 0;
        mode = 0; freeze_left = 0;
        m_score = 0; m_streak = 0; m_hit = 0; m_miss = 0;
        hist.delete();
    endtask

    task automatic model_step(int btn, logic [5:0] led);
        int all_diff;
        m_hit = 0;
        m_miss = 0;
        case (mode)
            0: if (m_press != 0) begin
                if (led == TMASK) begin
                    m_hit = 1;
                    if (m_score < 255) m_score++;
                    if (m_streak < 15) m_streak++;
                end else begin
                    m_miss = 1;
                    m_streak = 0;
                    if (m_score > 0) m_score--;
                end
                mode = 1;
                freeze_left = LOCK + 1;
            end
            1: begin
                freeze_left--;
                if (freeze_left == 0) mode = 2;
            end
            default: if (m_stable != 0) mode = 0;
        endcase
        m_press = 0;
        hist.push_back(m_s2);
        if (hist.size() > DEB) void'(hist.pop_front());
        if (hist.size() == DEB) begin
            all_diff = 1;
            foreach (hist[i]) if (hist[i] == m_stable) all_diff = 0;
            if (all_diff != 0) begin
                m_stable = 1 - m_stable;
                m_press = (m_stable == 0) ? 1 : 0;
                hist.delete();
            end
        end
        m_s2 = m_s1;
        m_s1 = btn;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step(int'(btn_n), led_index);
    end

    // Compare process plus DUT event tallies used by the directed checks.
    int cyc = 0, hit_cnt = 0, miss_cnt = 0, freeze_cnt = 0, hit_cyc = 0;

    initial forever begin
        int act, exp;
        @(negedge clk);
        cyc++;
        act = {17'd0, hit, miss, freeze, streak, score};
        if (!rst_n) exp = 0;
        else exp = (m_hit << 14) | (m_miss << 13) | ((freeze_left > 0 ? 1 : 0) << 12)
                   | (m_streak << 8) | m_score;
        check("outputs{hit,miss,freeze,streak,score}", act, exp);
        if (hit) begin hit_cnt++; hit_cyc = cyc; end
        if (miss) miss_cnt++;
        if (freeze) freeze_cnt++;
    end

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press(logic [5:0] led, int hold, int after);
        led_index = led;
        btn_n = 1'b0;
        wait_cyc(hold);
        btn_n = 1'b1;
        wait_cyc(after);
    endtask

    initial begin
        int h0, m0, f0, c0, guard, hold, gap, r;
        // Reset and idle
        wait_cyc(3);
        rst_n = 1'b1;
        f0 = freeze_cnt;
        wait_cyc(12);
        check("idle_freeze_cycles", freeze_cnt - f0, 0);
        check("idle_score", int'(score), 0);

        // Single hit: pulse 7 cycles after the edge, freeze for 9 cycles
        h0 = hit_cnt; f0 = freeze_cnt;
        c0 = cyc;
        press(6'b001000, 20, 30);
        check("hit_pulses", hit_cnt - h0, 1);
        check("hit_latency", hit_cyc - c0, 7);
        check("hit_freeze_cycles", freeze_cnt - f0, 9);
        check("hit_score", int'(score), 1);
        check("hit_streak", int'(streak), 1);

        // Two more hits then a miss
        press(TMASK, 12, 25);
        press(TMASK, 12, 25);
        m0 = miss_cnt;
        press(6'b000100, 12, 25);
        check("miss_pulses", miss_cnt - m0, 1);
        check("miss_score", int'(score), 2);
        check("miss_streak", int'(streak), 0);

        // Misses down to zero, then one more at zero
        press(6'b000001, 12, 25);
        press(6'b100000, 12, 25);
        press(6'b000010, 12, 25);
        check("miss_floor_score", int'(score), 0);

        // Bounce shorter than the debounce window
        h0 = hit_cnt; m0 = miss_cnt;
        led_index = TMASK;
        for (int i = 0; i < 15; i++) begin
            btn_n = ~btn_n;
            wait_cyc(2);
        end
        btn_n = 1'b1;
        wait_cyc(20);
        check("bounce_judgements", (hit_cnt - h0) + (miss_cnt - m0), 0);

        // Long hold judges exactly once
        h0 = hit_cnt; m0 = miss_cnt;
        press(TMASK, 80, 25);
        check("held_judgements", (hit_cnt - h0) + (miss_cnt - m0), 1);

        // Invalid patterns are misses
        m0 = miss_cnt;
        press(6'b001001, 12, 25);
        press(6'b000000, 12, 25);
        check("invalid_misses", miss_cnt - m0, 2);

        // Reset during lockout
        press(TMASK, 12, 25);
        led_index = TMASK;
        btn_n = 1'b0;
        guard = 0;
        while (!freeze && guard < 40) begin
            wait_cyc(1);
            guard++;
        end
        check("freeze_rise_in_time", int'(guard < 40), 1);
        wait_cyc(3);
        check("pre_reset_freeze", int'(freeze), 1);
        #1;
        rst_n = 1'b0;
        btn_n = 1'b1;
        #1;
        check("async_rst_freeze", int'(freeze), 0);
        check("async_rst_score", int'(score), 0);
        check("async_rst_streak", int'(streak), 0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(3);
        h0 = hit_cnt;
        press(TMASK, 10, 25);
        check("post_rst_hit", hit_cnt - h0, 1);
        check("post_rst_score", int'(score), 1);

        // Randomized presses, glitches, patterns and occasional resets
        for (int s = 0; s < 80; s++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: led_index = TMASK;
                1: led_index = 6'b1 << $urandom_range(0, 5);
                2: led_index = 6'($urandom);
                default: led_index = 6'b0;
            endcase
            hold = $urandom_range(1, 14);
            for (int i = 0; i < hold; i++) begin
                btn_n = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
                if ($urandom_range(0, 3) == 0) led_index = 6'($urandom);
                wait_cyc(1);
            end
            btn_n = 1'b1;
            gap = $urandom_range(1, 25);
            wait_cyc(gap);
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                wait_cyc(2);
                rst_n = 1'b1;
            end
        end
        wait_cyc(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
